// File: rtl/mem_port_arbiter.sv
// Single-ported RAM shared by the pipeline and the debug/loader port; same-cycle combinational grant,
// read data one cycle after the grant, and a denied requester holds its request (pipeline sees stall).
module mem_port_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic          clock,
   input  logic          reset,

   input  logic          p_req,
   input  logic          p_we,
   input  logic [AW-1:0] p_addr,
   input  logic [DW-1:0] p_wdata,
   output logic          p_gnt,
   output logic          p_rvalid,
   output logic [DW-1:0] p_rdata,
   output logic          stall,

   input  logic          d_req,
   input  logic          d_we,
   input  logic          d_lock,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,

   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      OWN_P,
      OWN_D,
      LOCK_D
   } state_t;

   localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] wait_cnt;
   logic [3:0] wait_nxt;

   // Reset gates every combinational output so nothing leaks to the RAM while held in reset.
   always_comb begin
      p_gnt = 1'b0;
      d_gnt = 1'b0;
      if (reset) begin
         if (state == LOCK_D) begin
            d_gnt = d_req;
         end else if (p_req && d_req) begin
            if (wait_cnt == WAIT_LIM) begin
               d_gnt = 1'b1;
            end else begin
               p_gnt = 1'b1;
            end
         end else begin
            p_gnt = p_req;
            d_gnt = d_req;
         end
      end
   end

   assign stall = reset & p_req & ~p_gnt;

   always_comb begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
      if (p_gnt) begin
         ram_addr  = p_addr;
         ram_we    = p_we;
         ram_wdata = p_wdata;
      end else if (d_gnt) begin
         ram_addr  = d_addr;
         ram_we    = d_we;
         ram_wdata = d_wdata;
      end
   end

   always_comb begin
      state_nxt = IDLE;
      if (state == LOCK_D) begin
         if (d_lock) begin
            state_nxt = LOCK_D;
         end else if (p_req) begin
            state_nxt = OWN_P;
         end else begin
            state_nxt = IDLE;
         end
      end else if (d_gnt && d_lock) begin
         state_nxt = LOCK_D;
      end else if (p_gnt) begin
         state_nxt = OWN_P;
      end else if (d_gnt) begin
         state_nxt = OWN_D;
      end
   end

   // Starvation counter only runs while the debug port is actually waiting.
   always_comb begin
      wait_nxt = 4'd0;
      if (d_req && !d_gnt) begin
         wait_nxt = (wait_cnt < WAIT_LIM) ? wait_cnt + 4'd1 : WAIT_LIM;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
         p_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         p_rvalid <= p_gnt & ~p_we;
         d_rvalid <= d_gnt & ~d_we;
      end
   end

   assign p_rdata = p_rvalid ? ram_rdata : '0;
   assign d_rdata = d_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: the driver runs a behavioural model and queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_mem_port_arbiter;

   localparam int AW       = 32;
   localparam int DW       = 32;
   localparam int MAX_WAIT = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          p_req, p_we, d_req, d_we, d_lock;
   logic [AW-1:0] p_addr, d_addr;
   logic [DW-1:0] p_wdata, d_wdata;
   logic          p_gnt, p_rvalid, stall, d_gnt, d_rvalid, ram_we;
   logic [DW-1:0] p_rdata, d_rdata, ram_wdata, ram_rdata;
   logic [AW-1:0] ram_addr;

   always #5 clock = ~clock;

   mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .clock(clock), .reset(reset),
      .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata), .stall(stall),
      .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   // Synchronous-read RAM attached to the DUT
   logic [DW-1:0] ram_mem [64];
   always @(posedge clock) begin
      if (ram_we) ram_mem[ram_addr[5:0]] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr[5:0]];
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int            due;
      logic          pg, dg, st, we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
   } cyc_exp_t;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } rd_exp_t;

   cyc_exp_t exp_q[$];
   rd_exp_t  p_rd_q[$];
   rd_exp_t  d_rd_q[$];

   // Reference model state: memory image, bus-lock flag, cycles the debug port has waited
   logic [DW-1:0] model_mem [64];
   bit            m_locked;
   int            m_starve;
   bit            m_last_pg, m_last_dg;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input bit rst_low,
                        input bit pr, input bit pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                        input bit dr, input bit dw, input bit dl, input logic [AW-1:0] da,
                        input logic [DW-1:0] dd);
      cyc_exp_t e;
      bit pg, dg;
      @(posedge clock);
      #1;
      reset = !rst_low;
      p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
      d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dd;
      pg = 1'b0;
      dg = 1'b0;
      if (!rst_low) begin
         if (m_locked) dg = dr;
         else if (pr && dr) begin
            if (m_starve == MAX_WAIT) dg = 1'b1;
            else pg = 1'b1;
         end else begin
            pg = pr;
            dg = dr;
         end
      end
      e.due  = cyc;
      e.pg   = pg;
      e.dg   = dg;
      e.st   = !rst_low && pr && !pg;
      e.we   = pg ? pw : (dg ? dw : 1'b0);
      e.addr = pg ? pa : (dg ? da : '0);
      e.wd   = pg ? pd : (dg ? dd : '0);
      if (rst_low) begin
         m_locked = 1'b0;
         m_starve = 0;
         p_rd_q.delete();
         d_rd_q.delete();
      end else begin
         if (pg) begin
            if (pw) model_mem[pa[5:0]] = pd;
            else p_rd_q.push_back('{cyc + 1, model_mem[pa[5:0]]});
         end
         if (dg) begin
            if (dw) model_mem[da[5:0]] = dd;
            else d_rd_q.push_back('{cyc + 1, model_mem[da[5:0]]});
         end
         if (dr && !dg) m_starve = (m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT;
         else m_starve = 0;
         m_locked = m_locked ? dl : (dg && dl);
      end
      m_last_pg = pg;
      m_last_dg = dg;
      exp_q.push_back(e);
   endtask

   task automatic idle(input bit rst_low);
      drive(rst_low, 0, 0, '0, '0, 0, 0, 0, '0, '0);
   endtask

   // Monitor
   cyc_exp_t me;
   rd_exp_t  mr;
   bit       pe, de;
   always @(negedge clock) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         me = exp_q.pop_front();
         check("p_gnt", 64'(p_gnt), 64'(me.pg));
         check("d_gnt", 64'(d_gnt), 64'(me.dg));
         check("stall", 64'(stall), 64'(me.st));
         check("ram_we", 64'(ram_we), 64'(me.we));
         check("ram_addr", 64'(ram_addr), 64'(me.addr));
         check("ram_wdata", 64'(ram_wdata), 64'(me.wd));
      end
      pe = p_rd_q.size() > 0 && p_rd_q[0].due == cyc;
      de = d_rd_q.size() > 0 && d_rd_q[0].due == cyc;
      check("p_rvalid", 64'(p_rvalid), 64'(pe));
      check("d_rvalid", 64'(d_rvalid), 64'(de));
      if (pe) begin
         mr = p_rd_q.pop_front();
         check("p_rdata", 64'(p_rdata), 64'(mr.data));
      end else begin
         check("p_rdata_idle", 64'(p_rdata), 64'd0);
      end
      if (de) begin
         mr = d_rd_q.pop_front();
         check("d_rdata", 64'(d_rdata), 64'(mr.data));
      end else begin
         check("d_rdata_idle", 64'(d_rdata), 64'd0);
      end
   end

   // Random stimulus with request holding until granted
   bit            rp_req, rp_we, rd_req, rd_we, rd_lock;
   logic [AW-1:0] rp_addr, rd_addr;
   logic [DW-1:0] rp_wdata, rd_wdata;

   initial begin
      reset = 1'b1;
      p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
      d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
      m_locked = 0; m_starve = 0; m_last_pg = 0; m_last_dg = 0;
      #2 reset = 1'b0;

      // Requests during reset must be ignored
      for (int i = 0; i < 3; i++)
         drive(1, 1, 0, 32'h8, $urandom, 1, 1, 1, 32'h4, $urandom);
      idle(0);

      // Preload through the debug port
      for (int a = 0; a < 64; a++)
         drive(0, 0, 0, '0, '0, 1, 1, 0, AW'(a), (a == 8) ? 32'h1E : $urandom);
      idle(0);

      // Single pipeline read of 0x8
      drive(0, 1, 0, 32'h8, '0, 0, 0, 0, '0, '0);
      idle(0);

      // Both ports held: debug starves MAX_WAIT cycles then wins
      for (int i = 0; i < MAX_WAIT + 1; i++)
         drive(0, 1, 0, AW'(4 * i), '0, 1, 0, 0, 32'h10, '0);
      idle(0);

      // Locked debug burst blocks the pipeline
      drive(0, 0, 0, '0, '0, 1, 1, 1, 32'h0, 32'hA0);
      drive(0, 1, 0, 32'h14, '0, 1, 1, 1, 32'h4, 32'hA4);
      drive(0, 1, 0, 32'h14, '0, 1, 1, 1, 32'h8, 32'hA8);
      drive(0, 1, 0, 32'h14, '0, 0, 0, 0, '0, '0);
      drive(0, 1, 0, 32'h14, '0, 0, 0, 0, '0, '0);
      idle(0);

      // Pipeline write then read-back
      drive(0, 1, 1, 32'h8, 32'hF, 0, 0, 0, '0, '0);
      drive(0, 1, 0, 32'h8, '0, 0, 0, 0, '0, '0);
      idle(0);

      // Reset right after a granted debug read; pipeline served right after release
      drive(0, 0, 0, '0, '0, 1, 0, 0, 32'h10, '0);
      drive(1, 1, 1, 32'h20, $urandom, 1, 0, 1, 32'h10, '0);
      drive(0, 1, 0, 32'h8, '0, 0, 0, 0, '0, '0);
      idle(0);

      rp_req = 0; rd_req = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!(rp_req && !m_last_pg)) begin
            rp_req   = $urandom_range(0, 2) != 0;
            rp_we    = $urandom_range(0, 1) != 0;
            rp_addr  = AW'($urandom_range(0, 63));
            rp_wdata = $urandom;
         end
         if (!(rd_req && !m_last_dg)) begin
            rd_req   = $urandom_range(0, 2) == 0;
            rd_we    = $urandom_range(0, 1) != 0;
            rd_addr  = AW'($urandom_range(0, 63));
            rd_wdata = $urandom;
            rd_lock  = m_locked ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         end
         drive($urandom_range(0, 299) == 0, rp_req, rp_we, rp_addr, rp_wdata,
               rd_req, rd_we, rd_lock, rd_addr, rd_wdata);
      end

      for (int i = 0; i < 3; i++) idle(0);
      @(negedge clock);
      #1;
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      check("p_rd_q_drained", 64'(p_rd_q.size()), 64'd0);
      check("d_rd_q_drained", 64'(d_rd_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
